// File: rtl/queen_solution_receiver_if.sv
// Row-word streaming bus between the N-queens solver and its receiver.
// The master drives one one-hot row word per beat; the slave returns in_ready.
interface queen_solution_receiver_if #(
  parameter int N = 8
);
  logic         in_valid;
  logic [N-1:0] in_data;
  logic         in_ready;

  modport master (output in_valid, output in_data, input  in_ready);
  modport slave  (input  in_valid, input  in_data, output in_ready);
endinterface

// File: rtl/queen_solution_receiver.sv
// Receives N-queens solution frames row by row, rebuilds the board and re-verifies it
// pair by pair, reporting a per-frame verdict, a saturating solution count and end of search.
module queen_solution_receiver #(
  parameter int N       = 8,
  parameter int COL_W   = 3,
  parameter int COUNT_W = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  queen_solution_receiver_if.slave   row_bus,
  input  logic                       solver_done,
  output logic                       sol_valid,
  output logic                       sol_ok,
  output logic                       err_onehot,
  output logic                       err_conflict,
  output logic                       err_truncated,
  output logic [COUNT_W-1:0]         sol_count,
  output logic                       finished,
  input  logic [COL_W-1:0]           rd_addr,
  output logic [COL_W-1:0]           rd_col
);

  typedef enum logic [1:0] {IDLE, RECV, CHECK, REPORT} state_t;

  localparam logic [COL_W-1:0] LAST_ROW = COL_W'(N - 1);
  localparam logic [COL_W-1:0] LAST_I   = COL_W'(N - 2);

  state_t             state, next_state;
  logic [COL_W-1:0]   board [N];
  logic [COL_W-1:0]   row_idx;
  logic [COL_W-1:0]   pair_i, pair_j;
  logic               done_pending;

  logic               handshake, last_beat, accept, truncate, last_pair;
  logic [COL_W-1:0]   enc_col;
  logic               onehot_ok;
  logic [COL_W:0]     col_a, col_b, col_diff, row_diff;
  logic               pair_conflict;

  assign row_bus.in_ready = reset && !finished && (state == IDLE || state == RECV);

  assign handshake = row_bus.in_valid && row_bus.in_ready;
  assign last_beat = (state == RECV) && (row_idx == LAST_ROW);
  // A done pulse beats an ordinary row, but never the row that completes the frame.
  assign accept    = handshake && !(solver_done && !last_beat);
  assign truncate  = (state == RECV) && solver_done && !accept;
  assign last_pair = (pair_i == LAST_I) && (pair_j == LAST_ROW);

  assign sol_valid = (state == REPORT);
  assign sol_ok    = (state == REPORT) && !err_onehot && !err_conflict;
  assign rd_col    = board[rd_addr];

  // Lowest set bit wins, so malformed words still map to a defined column.
  always_comb begin
    enc_col = '0;
    for (int c = N - 1; c >= 0; c--) begin
      if (row_bus.in_data[c]) enc_col = COL_W'(c);
    end
    onehot_ok = (row_bus.in_data != '0) &&
                ((row_bus.in_data & (row_bus.in_data - N'(1))) == '0);
  end

  always_comb begin
    col_a         = {1'b0, board[pair_i]};
    col_b         = {1'b0, board[pair_j]};
    col_diff      = (col_a >= col_b) ? (col_a - col_b) : (col_b - col_a);
    row_diff      = {1'b0, pair_j} - {1'b0, pair_i};
    pair_conflict = (col_diff == '0) || (col_diff == row_diff);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (accept) next_state = RECV;
      RECV:    if (accept && last_beat) next_state = CHECK;
               else if (truncate)       next_state = IDLE;
      CHECK:   if (last_pair) next_state = REPORT;
      REPORT:  next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int r = 0; r < N; r++) board[r] <= '0;
      row_idx       <= '0;
      pair_i        <= '0;
      pair_j        <= COL_W'(1);
      err_onehot    <= 1'b0;
      err_conflict  <= 1'b0;
      err_truncated <= 1'b0;
      sol_count     <= '0;
      finished      <= 1'b0;
      done_pending  <= 1'b0;
    end else begin
      err_truncated <= 1'b0;

      if (accept) begin
        board[row_idx] <= enc_col;
        row_idx        <= last_beat ? '0 : row_idx + COL_W'(1);
        if (row_idx == '0) begin
          err_onehot   <= !onehot_ok;
          err_conflict <= 1'b0;
        end else if (!onehot_ok) begin
          err_onehot   <= 1'b1;
        end
        if (last_beat && solver_done) done_pending <= 1'b1;
      end

      if (truncate) begin
        row_idx       <= '0;
        err_truncated <= 1'b1;
        finished      <= 1'b1;
      end

      if (state == IDLE && solver_done) finished <= 1'b1;

      // Full triangular sweep of row pairs, no early exit.
      if (state == CHECK) begin
        if (pair_conflict) err_conflict <= 1'b1;
        if (last_pair) begin
          pair_i <= '0;
          pair_j <= COL_W'(1);
        end else if (pair_j == LAST_ROW) begin
          pair_i <= pair_i + COL_W'(1);
          pair_j <= pair_i + COL_W'(2);
        end else begin
          pair_j <= pair_j + COL_W'(1);
        end
        if (solver_done) done_pending <= 1'b1;
      end

      if (state == REPORT) begin
        if (sol_ok && !(&sol_count)) sol_count <= sol_count + COUNT_W'(1);
        if (done_pending || solver_done) finished <= 1'b1;
        done_pending <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_queen_solution_receiver.sv
// Directed bench for queen_solution_receiver: frame verdicts, latency, truncation,
// pending done and mid-check reset, all against hand-computed expectations.
module tb_queen_solution_receiver;

  logic       clk = 1'b0;
  logic       reset;
  logic       solver_done;
  logic       sol_valid, sol_ok, err_onehot, err_conflict, err_truncated, finished;
  logic [7:0] sol_count;
  logic [2:0] rd_addr, rd_col;

  int vectors     = 0;
  int miscompares = 0;
  int lat;
  int seen;

  queen_solution_receiver_if #(.N(8)) bus ();

  queen_solution_receiver #(.N(8), .COL_W(3), .COUNT_W(8)) dut (
    .clk           (clk),
    .reset         (reset),
    .row_bus       (bus.slave),
    .solver_done   (solver_done),
    .sol_valid     (sol_valid),
    .sol_ok        (sol_ok),
    .err_onehot    (err_onehot),
    .err_conflict  (err_conflict),
    .err_truncated (err_truncated),
    .sol_count     (sol_count),
    .finished      (finished),
    .rd_addr       (rd_addr),
    .rd_col        (rd_col)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    if (observed !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] beat);
    bus.in_valid = 1'b1;
    bus.in_data  = beat;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  // Beat k is frame[8k+:8]; returns edges from last accept to the first sol_valid sample.
  task automatic runFrame(input logic [63:0] frame, input bit hold, input int done_at, output int latency);
    for (int k = 0; k < 8; k++) applyStimulus(frame[k*8 +: 8]);
    bus.in_valid = hold;
    bus.in_data  = 8'h80;
    latency = 0;
    while (!sol_valid && latency < 100) begin
      solver_done = (done_at != 0) && (latency == done_at);
      @(posedge clk); #1;
      latency++;
      solver_done = 1'b0;
      if (hold && latency == 5) checkOutput("hold_in_ready", 32'(bus.in_ready), 32'd0);
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic checkRow(input string tag, input logic [2:0] row, input logic [2:0] col);
    rd_addr = row;
    #1;
    checkOutput(tag, 32'(rd_col), 32'(col));
  endtask

  initial begin
    reset        = 1'b0;
    solver_done  = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    rd_addr      = '0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_in_ready", 32'(bus.in_ready), 32'd0);
    checkOutput("rst_sol_valid", 32'(sol_valid), 32'd0);
    checkOutput("rst_count", 32'(sol_count), 32'd0);
    checkOutput("rst_finished", 32'(finished), 32'd0);
    reset = 1'b1;
    @(posedge clk); #1;
    checkOutput("post_rst_in_ready", 32'(bus.in_ready), 32'd1);

    // Legal solution: columns 0,4,7,5,2,6,1,3.
    runFrame(64'h0802400420801001, 1'b0, 0, lat);
    checkOutput("t1_latency", 32'(lat), 32'd28);
    checkOutput("t1_sol_ok", 32'(sol_ok), 32'd1);
    checkOutput("t1_err_conflict", 32'(err_conflict), 32'd0);
    checkOutput("t1_err_onehot", 32'(err_onehot), 32'd0);
    @(posedge clk); #1;
    checkOutput("t1_count", 32'(sol_count), 32'd1);
    checkOutput("t1_in_ready", 32'(bus.in_ready), 32'd1);
    checkRow("t1_row2", 3'd2, 3'd7);
    checkRow("t1_row1", 3'd1, 3'd4);

    // Column clash rows 0/1.
    runFrame(64'h1002400420800101, 1'b0, 0, lat);
    checkOutput("t2_sol_ok", 32'(sol_ok), 32'd0);
    checkOutput("t2_err_conflict", 32'(err_conflict), 32'd1);
    checkOutput("t2_err_onehot", 32'(err_onehot), 32'd0);
    @(posedge clk); #1;
    checkOutput("t2_count", 32'(sol_count), 32'd1);

    // Diagonal clash rows 0/1.
    runFrame(64'h0802400420800201, 1'b0, 0, lat);
    checkOutput("t3_latency", 32'(lat), 32'd28);
    checkOutput("t3_err_conflict", 32'(err_conflict), 32'd1);
    @(posedge clk); #1;

    // Row 3 all-zero, then row 3 with two bits set.
    runFrame(64'h0802400400801001, 1'b0, 0, lat);
    checkOutput("t4a_err_onehot", 32'(err_onehot), 32'd1);
    checkOutput("t4a_sol_ok", 32'(sol_ok), 32'd0);
    @(posedge clk); #1;
    checkRow("t4a_row3", 3'd3, 3'd0);
    runFrame(64'h0802400418801001, 1'b0, 0, lat);
    checkOutput("t4b_err_onehot", 32'(err_onehot), 32'd1);
    checkOutput("t4b_sol_ok", 32'(sol_ok), 32'd0);
    @(posedge clk); #1;
    checkRow("t4b_row3", 3'd3, 3'd3);
    checkOutput("t4_count", 32'(sol_count), 32'd1);

    // in_valid held with 0x80 during CHECK must not overwrite row 0.
    runFrame(64'h0802400420801001, 1'b1, 0, lat);
    checkOutput("t5_latency", 32'(lat), 32'd28);
    checkOutput("t5_sol_ok", 32'(sol_ok), 32'd1);
    @(posedge clk); #1;
    checkRow("t5_row0", 3'd0, 3'd0);
    checkOutput("t5_count", 32'(sol_count), 32'd2);
    runFrame(64'h0802400420801001, 1'b0, 0, lat);
    checkOutput("t5_next_sol_ok", 32'(sol_ok), 32'd1);
    @(posedge clk); #1;
    checkOutput("t5_next_count", 32'(sol_count), 32'd3);

    // Truncated frame.
    applyStimulus(8'h01);
    applyStimulus(8'h10);
    applyStimulus(8'h80);
    solver_done = 1'b1;
    @(posedge clk); #1;
    solver_done = 1'b0;
    checkOutput("t6_err_truncated", 32'(err_truncated), 32'd1);
    checkOutput("t6_finished", 32'(finished), 32'd1);
    checkOutput("t6_in_ready", 32'(bus.in_ready), 32'd0);
    @(posedge clk); #1;
    checkOutput("t6_trunc_pulse_end", 32'(err_truncated), 32'd0);
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h01;
    seen = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (sol_valid) seen++;
    end
    bus.in_valid = 1'b0;
    checkOutput("t6_no_sol_valid", 32'(seen), 32'd0);
    checkOutput("t6_count", 32'(sol_count), 32'd3);
    checkOutput("t6_finished_sticky", 32'(finished), 32'd1);

    // Reset mid-CHECK.
    reset = 1'b0;
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    for (int k = 0; k < 8; k++) applyStimulus(8'h01);
    repeat (10) @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    checkOutput("t7_sol_valid", 32'(sol_valid), 32'd0);
    checkOutput("t7_in_ready", 32'(bus.in_ready), 32'd0);
    checkOutput("t7_count", 32'(sol_count), 32'd0);
    checkOutput("t7_err_onehot", 32'(err_onehot), 32'd0);
    checkOutput("t7_finished", 32'(finished), 32'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    checkOutput("t7_in_ready_after", 32'(bus.in_ready), 32'd1);

    // solver_done during CHECK is held until after the verdict.
    runFrame(64'h0802400420801001, 1'b0, 5, lat);
    checkOutput("t8_latency", 32'(lat), 32'd28);
    checkOutput("t8_finished_early", 32'(finished), 32'd0);
    @(posedge clk); #1;
    checkOutput("t8_finished", 32'(finished), 32'd1);
    checkOutput("t8_count", 32'(sol_count), 32'd1);
    checkOutput("t8_in_ready", 32'(bus.in_ready), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
